// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and width helpers for the 7-segment scan driver.
//   SEG_OFF    : segment pattern with every segment dark
//   MAX_DIGITS : largest digit count the scan driver supports
//   dig_off()  : digit-enable vector with every (active-low) enable off
//   width_of() : counter width able to hold 0..n-1 (never below 1 bit)
package seg7_pkg;

  localparam int         MAX_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h00;

  function automatic logic [MAX_DIGITS-1:0] dig_off();
    return '1;
  endfunction

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot timing for the scan driver.
//   r_pc counts clock cycles inside a digit slot (0..SCAN_DIV-1).
//   r_idx selects the digit being scanned (0..NUM_DIGITS-1, 0 first).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     i_en        : scan enable; low parks the scan at pc=0, idx=0
//     o_blank     : current cycle lies in the anti-ghosting gap of the slot
//     o_snap      : this edge starts a frame (enabled, pc=0, idx=0)
//     o_idx       : digit currently being scanned
//     o_pc        : cycle position inside the current slot (debug visibility)
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 7,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int PC_W         = width_of(SCAN_DIV),
  parameter int IDX_W        = width_of(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic             o_blank,
  output logic             o_snap,
  output logic [IDX_W-1:0] o_idx,
  output logic [PC_W-1:0]  o_pc
);

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0]  PC_BLANK = PC_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PC_W-1:0]  r_pc;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_idx <= '0;
    end else if (!i_en) begin
      // Disabled: park so the next enabled edge is a clean frame start.
      r_pc  <= '0;
      r_idx <= '0;
    end else if (r_pc == PC_LAST) begin
      r_pc  <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_pc  <= r_pc + PC_W'(1);
    end
  end

  assign o_blank = (r_pc < PC_BLANK);
  assign o_snap  = i_en && (r_pc == '0) && (r_idx == '0);
  assign o_idx   = r_idx;
  assign o_pc    = r_pc;

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 7-segment display driver.
//   Scans NUM_DIGITS digits round-robin (digit 0 first), blanking every
//   digit for BLANK_CYCLES at the start of each SCAN_DIV-cycle slot, and
//   snapshots all digit inputs once per frame so a frame never tears.
//   Outputs are registered from the current slot position (1-cycle latency).
//   Optional feature macro: SEG7_SCAN_BLINK_EN (per-digit blinking with a
//   half-period of 2^BLINK_LOG2 frames). Without it blink_i is ignored.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en_i       : scan enable; low = dark, scan restarts at digit 0
//     digits_i   : segment codes, digit k at [7k+6:7k] (1 = lit)
//     dp_i       : decimal point per digit (1 = lit)
//     blink_i    : per-digit blink request
//     seg_o      : shared segment bus (1 = lit)
//     dp_o       : shared decimal point
//     dig_o      : active-low digit enables, at most one low
//     frame_o    : 1-cycle pulse after each snapshot / frame start
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 7,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 50,
  parameter int BLINK_LOG2   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [7*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_o,
  output logic                    frame_o
);

  localparam int PC_W  = width_of(SCAN_DIV);
  localparam int IDX_W = width_of(NUM_DIGITS);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS || BLANK_CYCLES < 1 ||
      SCAN_DIV <= BLANK_CYCLES || BLINK_LOG2 < 0) begin : g_bad_params
    $error("seg7_scan_mux: illegal parameter set");
  end

  localparam logic [MAX_DIGITS-1:0] DIG_OFF_MAX = dig_off();
  localparam logic [NUM_DIGITS-1:0] DIG_ALL_OFF = DIG_OFF_MAX[NUM_DIGITS-1:0];

  logic             w_blank;
  logic             w_snap;
  logic [IDX_W-1:0] w_idx;
  logic [PC_W-1:0]  w_pc;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .PC_W        (PC_W),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en_i),
    .o_blank(w_blank),
    .o_snap (w_snap),
    .o_idx  (w_idx),
    .o_pc   (w_pc)
  );

  // Slot position is exposed by the timer for debug; only blank/snap are used here.
  logic w_unused_pc;
  assign w_unused_pc = ^w_pc;

  logic [7*NUM_DIGITS-1:0] r_snap_seg;
  logic [NUM_DIGITS-1:0]   r_snap_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_seg <= '0;
      r_snap_dp  <= '0;
    end else if (w_snap) begin
      r_snap_seg <= digits_i;
      r_snap_dp  <= dp_i;
    end
  end

  // Select the scanned digit by shifting it down to bit 0.
  logic [7*NUM_DIGITS-1:0] w_seg_shift;
  logic [NUM_DIGITS-1:0]   w_dp_shift;
  logic [6:0]              w_seg_sel;
  logic                    w_dp_sel;
  logic [NUM_DIGITS-1:0]   w_dig_on;

  assign w_seg_shift = r_snap_seg >> (7 * int'(w_idx));
  assign w_dp_shift  = r_snap_dp >> w_idx;
  assign w_seg_sel   = w_seg_shift[6:0];
  assign w_dp_sel    = w_dp_shift[0];
  assign w_dig_on    = ~(NUM_DIGITS'(1) << w_idx);

  logic w_blink_off;

`ifdef SEG7_SCAN_BLINK_EN
  logic [BLINK_LOG2:0]   r_fcnt;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] r_snap_blink;
  logic [NUM_DIGITS-1:0] w_blink_shift;

  // Phase is taken from the frame count before it advances, so frames
  // 0..2^BLINK_LOG2-1 after reset are shown lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt       <= '0;
      r_phase      <= 1'b0;
      r_snap_blink <= '0;
    end else if (w_snap) begin
      r_fcnt       <= r_fcnt + (BLINK_LOG2 + 1)'(1);
      r_phase      <= r_fcnt[BLINK_LOG2];
      r_snap_blink <= blink_i;
    end
  end

  assign w_blink_shift = r_snap_blink >> w_idx;
  assign w_blink_off   = r_phase & w_blink_shift[0];
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_i;
  assign w_blink_off    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b0;
      dig_o   <= DIG_ALL_OFF;
      frame_o <= 1'b0;
    end else begin
      frame_o <= w_snap;
      if (!en_i || w_blank || w_blink_off) begin
        seg_o <= SEG_OFF;
        dp_o  <= 1'b0;
        dig_o <= DIG_ALL_OFF;
      end else begin
        seg_o <= w_seg_sel;
        dp_o  <= w_dp_sel;
        dig_o <= w_dig_on;
      end
    end
  end

endmodule
